// File: rtl/node_mem_ctrl.sv
// Node memory controller: a single-port-style RAM with a GET/SET/ALLOC request FSM
// and a bump-pointer allocator with a sticky out-of-memory flag.
module node_mem_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int FREE_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_execute,
  input  logic [1:0]        mem_func,
  input  logic [ADDR_W-1:0] address1,
  input  logic [ADDR_W-1:0] address2,
  input  logic [DATA_W-1:0] write_data,
  output logic              mem_ready,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [ADDR_W-1:0] free_addr,
  output logic              mem_error
);

  localparam logic [1:0] F_GET   = 2'b01;
  localparam logic [1:0] F_SET   = 2'b10;
  localparam logic [1:0] F_ALLOC = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] FREE_RST  = ADDR_W'(FREE_BASE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD1   = 3'd1,
    RD2   = 3'd2,
    WR    = 3'd3,
    ALLOC = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [ADDR_W-1:0] free_q, free_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_rdata_q;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata;

  // GET reads address1 on the accepting edge, so each captured word lands one
  // state later: RD1 captures word 1 and reads address2, RD2 captures word 2.
  always_comb begin
    state_d   = state_q;
    addr1_d   = addr1_q;
    addr2_d   = addr2_q;
    wdata_d   = wdata_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    free_d    = free_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    ram_waddr = addr1_q;
    ram_wdata = wdata_q;
    ram_re    = 1'b0;
    ram_raddr = addr1_q;

    case (state_q)
      IDLE: begin
        if (mem_execute && (mem_func != 2'b00)) begin
          addr1_d = address1;
          addr2_d = address2;
          wdata_d = write_data;
          case (mem_func)
            F_GET: begin
              state_d   = RD1;
              ram_re    = 1'b1;
              ram_raddr = address1;
            end
            F_SET:   state_d = WR;
            F_ALLOC: state_d = ALLOC;
            default: state_d = IDLE;
          endcase
        end
      end
      RD1: begin
        rd1_d     = ram_rdata_q;
        ram_re    = 1'b1;
        ram_raddr = addr2_q;
        state_d   = RD2;
      end
      RD2: begin
        rd2_d   = ram_rdata_q;
        state_d = DONE;
      end
      WR: begin
        ram_we  = 1'b1;
        state_d = DONE;
      end
      ALLOC: begin
        // The last word is never handed out; a full heap flags the error and
        // still completes so the requester is not left waiting.
        if (free_q != LAST_ADDR) begin
          ram_we    = 1'b1;
          ram_waddr = free_q;
          rd1_d     = {{(DATA_W-ADDR_W){1'b0}}, free_q};
          free_d    = free_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr1_q <= '0;
      addr2_q <= '0;
      wdata_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      free_q  <= FREE_RST;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      wdata_q <= wdata_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      free_q  <= free_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  // Write enable is derived from state_q, which reset clears asynchronously,
  // so an aborted SET/ALLOC can never reach the array.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    if (ram_re) begin
      ram_rdata_q <= mem[ram_raddr];
    end
  end

  assign mem_ready  = ready_q;
  assign read_data1 = rd1_q;
  assign read_data2 = rd2_q;
  assign free_addr  = free_q;
  assign mem_error  = err_q;

endmodule

// File: tb/tb_node_mem_ctrl.sv
// Self-checking bench for node_mem_ctrl: reference model plus an expected-data
// queue that is filled when a request is driven and drained on mem_ready.
module tb_node_mem_ctrl;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int FB = 16;
  localparam logic [1:0] F_NOP   = 2'b00;
  localparam logic [1:0] F_GET   = 2'b01;
  localparam logic [1:0] F_SET   = 2'b10;
  localparam logic [1:0] F_ALLOC = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_execute;
  logic [1:0]    mem_func;
  logic [AW-1:0] address1, address2;
  logic [DW-1:0] write_data;
  logic          mem_ready;
  logic [DW-1:0] read_data1, read_data2;
  logic [AW-1:0] free_addr;
  logic          mem_error;

  node_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FREE_BASE(FB)) dut (
    .clk(clk), .rst(rst), .mem_execute(mem_execute), .mem_func(mem_func),
    .address1(address1), .address2(address2), .write_data(write_data),
    .mem_ready(mem_ready), .read_data1(read_data1), .read_data2(read_data2),
    .free_addr(free_addr), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [DW-1:0] exp_q[$];

  logic [DW-1:0] m_mem [32];
  logic [AW-1:0] m_free;
  logic          m_err;
  logic [DW-1:0] m_rd1, m_rd2;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_free = AW'(FB);
    m_err  = 1'b0;
    m_rd1  = '0;
    m_rd2  = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ready"}, DW'(mem_ready), DW'(0));
    check({tag, ".rd1"}, read_data1, '0);
    check({tag, ".rd2"}, read_data2, '0);
    check({tag, ".free"}, DW'(free_addr), DW'(FB));
    check({tag, ".err"}, DW'(mem_error), DW'(0));
  endtask

  // Called at a negedge; drives the request immediately so a call right after a
  // completion lands the strobe in the cycle following mem_ready.
  task automatic run_req(input string tag, input logic [1:0] f, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [DW-1:0] wd,
                         input int hold, input int lat);
    int first, pulses, bound;
    logic [DW-1:0] e1, e2;
    case (f)
      F_GET: begin
        m_rd1 = m_mem[a1];
        m_rd2 = m_mem[a2];
      end
      F_SET: m_mem[a1] = wd;
      F_ALLOC: begin
        if (m_free != 5'd31) begin
          m_mem[m_free] = wd;
          m_rd1 = DW'(m_free);
          m_free = m_free + 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      default: ;
    endcase
    exp_q.push_back(m_rd1);
    exp_q.push_back(m_rd2);

    mem_execute = 1'b1;
    mem_func    = f;
    address1    = a1;
    address2    = a2;
    write_data  = wd;
    first  = 0;
    pulses = 0;
    bound  = (hold == 1) ? lat + 1 : hold + lat + 2;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      if (n >= hold) begin
        mem_execute = 1'b0;
        mem_func    = F_NOP;
      end
      if (mem_ready === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = n;
          e1 = exp_q.pop_front();
          e2 = exp_q.pop_front();
          check({tag, ".rd1"}, read_data1, e1);
          check({tag, ".rd2"}, read_data2, e2);
          check({tag, ".free"}, DW'(free_addr), DW'(m_free));
          check({tag, ".err"}, DW'(mem_error), DW'(m_err));
        end
      end
    end
    check({tag, ".latency"}, DW'(first), DW'(lat));
    check({tag, ".pulses"}, DW'(pulses), DW'(1));
    if (first == 0) begin
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int pulses;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    model_reset();
    rst = 1'b1;
    mem_execute = 1'b0;
    mem_func = F_NOP;
    address1 = '0;
    address2 = '0;
    write_data = '0;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // NOP with strobe high must stay silent
    mem_execute = 1'b1;
    mem_func = F_NOP;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("nop.ready", DW'(mem_ready), DW'(0));
    end
    mem_execute = 1'b0;
    @(negedge clk);

    run_req("set5", F_SET, 5'd5, 5'd0, 64'h0000_0001_0000_0002, 1, 2);
    run_req("get5", F_GET, 5'd5, 5'd5, 64'h0, 1, 3);

    run_req("alloc_a", F_ALLOC, 5'd0, 5'd0, 64'hAAAA_0000_1111_0001, 1, 2);
    check("alloc_a.rd1", read_data1, DW'(16));
    run_req("alloc_b", F_ALLOC, 5'd0, 5'd0, 64'hBBBB_0000_2222_0002, 1, 2);
    check("alloc_b.free", DW'(free_addr), DW'(18));
    run_req("get_ab", F_GET, 5'd16, 5'd17, 64'h0, 1, 3);

    run_req("set31", F_SET, 5'd31, 5'd0, 64'hC0FF_EE00_3131_3131, 1, 2);
    run_req("set7", F_SET, 5'd7, 5'd0, 64'h7777_0000_0000_0007, 1, 2);

    for (int i = 0; i < 8; i++) begin
      ra = AW'($urandom_range(0, 15));
      rd = {$urandom(), $urandom()};
      run_req("rnd_set", F_SET, ra, 5'd0, rd, 1, 2);
      run_req("rnd_get", F_GET, ra, (i % 2 == 0) ? 5'd16 : 5'd31, 64'h0, 1, 3);
    end

    run_req("hold4", F_GET, 5'd17, 5'd16, 64'h0, 4, 3);
    run_req("b2b", F_GET, 5'd16, 5'd17, 64'h0, 1, 3);

    // Reset while the SET sits in WR: no write, no completion
    mem_execute = 1'b1;
    mem_func = F_SET;
    address1 = 5'd7;
    write_data = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clk);
    mem_execute = 1'b0;
    mem_func = F_NOP;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_outputs("rst_wr");
    mem_execute = 1'b1;
    mem_func = F_GET;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) pulses++;
    end
    mem_execute = 1'b0;
    mem_func = F_NOP;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) pulses++;
    end
    check("rst_wr.pulses", DW'(pulses), DW'(0));
    run_req("get7", F_GET, 5'd7, 5'd7, 64'h0, 1, 3);

    // Fill the heap 16..30, then hit the last word
    for (int i = 0; i < 15; i++) begin
      run_req("fill", F_ALLOC, 5'd0, 5'd0, DW'(64'h1000 + i), 1, 2);
    end
    run_req("full", F_ALLOC, 5'd0, 5'd0, 64'hBAD0_BAD0_BAD0_BAD0, 1, 2);
    check("full.err", DW'(mem_error), DW'(1));
    check("full.free", DW'(free_addr), DW'(31));
    run_req("full2", F_ALLOC, 5'd0, 5'd0, 64'hBAD1_BAD1_BAD1_BAD1, 1, 2);
    run_req("get31", F_GET, 5'd31, 5'd30, 64'h0, 1, 3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
